// File: rtl/sdp_rdma_layer_seq.sv
// sdp_rdma_layer_seq
// Read-DMA layer sequencer for SDP operand fetch. Walks a 2D surface of
// atoms line by line, issuing read requests of up to MAX_BURST atoms. Each
// accepted request is remembered in a context queue (CQ) until all of its
// response beats are back. dp2reg_done pulses once the surface has been fully
// requested and every outstanding request has drained.
//
// Build option: define SDP_RDMA_MULTI_SURF_EN to fetch reg2dp_channel+1
// surfaces spaced by reg2dp_surface_stride. Without it a single surface is
// fetched and those two ports do not exist.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn  clock, synchronous active-low reset
//   reg2dp_op_en                       layer enable (starts a layer when idle)
//   reg2dp_base_addr                   surface base byte address
//   reg2dp_line_stride                 byte stride between lines
//   reg2dp_width / reg2dp_height       atoms per line - 1 / lines - 1
//   reg2dp_perf_dma_en                 enable request stall counting
//   reg2dp_channel                     surfaces - 1 (multi-surface build only)
//   reg2dp_surface_stride              byte stride between surfaces (multi-surface build only)
//   dma_rd_req_*                       read request channel (valid/ready/addr/size)
//   dma_rd_rsp_valid / _ready          response beats, one atom per beat
//   op_load                            layer-start pulse (combinational)
//   layer_process                      layer active
//   dp2reg_done                        one-cycle layer-done pulse
//   dp2reg_stall                       saturating request stall cycle count
//   cq_count                           outstanding requests in the CQ
//
// State table:
//   state    | meaning
//   ST_IDLE  | no layer active, waiting for op_load
//   ST_REQ   | walking the surface and issuing read requests
//   ST_DRAIN | all requests issued, waiting for outstanding beats to return

module sdp_rdma_layer_seq #(
    parameter int  AW         = 64,
    parameter int  LEN_W      = 13,
    parameter int  CQ_DEPTH   = 16,
    parameter int  MAX_BURST  = 4,
    parameter int  ATOM_BYTES = 32,
    parameter int  STALL_W    = 32,
    localparam int SZ_W       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
    localparam int CNT_W      = $clog2(CQ_DEPTH) + 1
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic               reg2dp_op_en,
    input  logic [AW-1:0]      reg2dp_base_addr,
    input  logic [31:0]        reg2dp_line_stride,
    input  logic [LEN_W-1:0]   reg2dp_width,
    input  logic [LEN_W-1:0]   reg2dp_height,
    input  logic               reg2dp_perf_dma_en,
`ifdef SDP_RDMA_MULTI_SURF_EN
    input  logic [LEN_W-1:0]   reg2dp_channel,
    input  logic [31:0]        reg2dp_surface_stride,
`endif
    output logic               dma_rd_req_valid,
    input  logic               dma_rd_req_ready,
    output logic [AW-1:0]      dma_rd_req_addr,
    output logic [SZ_W-1:0]    dma_rd_req_size,
    input  logic               dma_rd_rsp_valid,
    output logic               dma_rd_rsp_ready,
    output logic               op_load,
    output logic               layer_process,
    output logic               dp2reg_done,
    output logic [STALL_W-1:0] dp2reg_stall,
    output logic [CNT_W-1:0]   cq_count
);

    localparam int               PTR_W   = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;
    localparam int               ATOM_SH = $clog2(ATOM_BYTES);
    localparam logic [LEN_W:0]   ONE_L   = (LEN_W + 1)'(1);
    localparam logic [LEN_W:0]   MAXB_L  = (LEN_W + 1)'(MAX_BURST);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(CQ_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               layer_process_q, layer_process_d;
    logic               done_q, done_d;
    logic [31:0]        stride_q, stride_d;
    logic [LEN_W-1:0]   width_q, width_d;
    logic [LEN_W-1:0]   height_q, height_d;
    logic [LEN_W-1:0]   x_q, x_d;
    logic [LEN_W-1:0]   y_q, y_d;
    logic [AW-1:0]      line_addr_q, line_addr_d;
    logic [STALL_W-1:0] stall_q, stall_d;
`ifdef SDP_RDMA_MULTI_SURF_EN
    logic [LEN_W-1:0]   channel_q, channel_d;
    logic [LEN_W-1:0]   surf_q, surf_d;
    logic [31:0]        surf_stride_q, surf_stride_d;
    logic [AW-1:0]      surf_addr_q, surf_addr_d;
`endif

    logic [SZ_W-1:0]    cq_mem_q [CQ_DEPTH];
    logic [SZ_W-1:0]    cq_mem_d [CQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cq_count_q, cq_count_d;
    logic [SZ_W-1:0]    beat_q, beat_d;

    logic [LEN_W:0]     remain;
    logic [LEN_W:0]     x_adv;
    logic [SZ_W-1:0]    req_size;
    logic [AW-1:0]      req_addr;
    logic [SZ_W-1:0]    head_size;
    logic               cq_full;
    logic               cq_empty;
    logic               req_fire;
    logic               rsp_fire;
    logic               pop;
    logic               last_col;
    logic               last_line;

    // Request geometry. x only moves on accept, so addr/size are stable while
    // a request is waiting for ready (including while the CQ is full).
    always_comb begin
        remain   = {1'b0, width_q} + ONE_L - {1'b0, x_q};
        req_size = (remain >= MAXB_L) ? SZ_W'(MAX_BURST - 1) : SZ_W'(remain - ONE_L);
        x_adv    = {1'b0, x_q} + (LEN_W + 1)'(req_size) + ONE_L;
        req_addr = line_addr_q + (AW'(x_q) << ATOM_SH);
    end

    assign last_col  = (x_adv == ({1'b0, width_q} + ONE_L));
    assign last_line = (y_q == height_q);

    assign cq_full   = (cq_count_q == FULL_C);
    assign cq_empty  = (cq_count_q == '0);
    assign head_size = cq_mem_q[rd_ptr_q];

    // Held low during reset so every output reads 0 while rstn is asserted.
    assign op_load          = nvdla_core_rstn & reg2dp_op_en & ~layer_process_q;
    assign dma_rd_req_valid = (state_q == ST_REQ) & ~cq_full;
    assign dma_rd_req_addr  = req_addr;
    assign dma_rd_req_size  = req_size;
    assign dma_rd_rsp_ready = ~cq_empty;

    assign req_fire = dma_rd_req_valid & dma_rd_req_ready;
    assign rsp_fire = dma_rd_rsp_valid & dma_rd_rsp_ready;
    // The head entry retires on its last beat (beat index == size).
    assign pop      = rsp_fire & (beat_q == head_size);

    // Context queue: size of each outstanding request, plus a beat counter
    // for the entry at the head.
    always_comb begin
        cq_mem_d   = cq_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cq_count_d = cq_count_q;
        beat_d     = beat_q;

        if (req_fire) begin
            cq_mem_d[wr_ptr_q] = req_size;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end

        if (rsp_fire) begin
            if (pop) begin
                beat_d   = '0;
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                beat_d   = beat_q + SZ_W'(1);
            end
        end

        case ({req_fire, pop})
            2'b10:   cq_count_d = cq_count_q + CNT_W'(1);
            2'b01:   cq_count_d = cq_count_q - CNT_W'(1);
            default: cq_count_d = cq_count_q;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (op_load) begin
            stall_d = '0;
        end else if (reg2dp_perf_dma_en & dma_rd_req_valid & ~dma_rd_req_ready & ~(&stall_q)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    // FSM and surface walk.
    always_comb begin
        state_d         = state_q;
        layer_process_d = layer_process_q;
        done_d          = 1'b0;
        stride_d        = stride_q;
        width_d         = width_q;
        height_d        = height_q;
        x_d             = x_q;
        y_d             = y_q;
        line_addr_d     = line_addr_q;
`ifdef SDP_RDMA_MULTI_SURF_EN
        channel_d       = channel_q;
        surf_d          = surf_q;
        surf_stride_d   = surf_stride_q;
        surf_addr_d     = surf_addr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (op_load) begin
                    state_d         = ST_REQ;
                    layer_process_d = 1'b1;
                    stride_d        = reg2dp_line_stride;
                    width_d         = reg2dp_width;
                    height_d        = reg2dp_height;
                    x_d             = '0;
                    y_d             = '0;
                    line_addr_d     = reg2dp_base_addr;
`ifdef SDP_RDMA_MULTI_SURF_EN
                    channel_d       = reg2dp_channel;
                    surf_d          = '0;
                    surf_stride_d   = reg2dp_surface_stride;
                    surf_addr_d     = reg2dp_base_addr;
`endif
                end
            end

            ST_REQ: begin
                if (req_fire) begin
                    if (last_col) begin
                        x_d = '0;
                        if (last_line) begin
`ifdef SDP_RDMA_MULTI_SURF_EN
                            if (surf_q == channel_q) begin
                                state_d = ST_DRAIN;
                            end else begin
                                y_d         = '0;
                                surf_d      = surf_q + LEN_W'(1);
                                surf_addr_d = surf_addr_q + AW'(surf_stride_q);
                                line_addr_d = surf_addr_d;
                            end
`else
                            state_d = ST_DRAIN;
`endif
                        end else begin
                            y_d         = y_q + LEN_W'(1);
                            line_addr_d = line_addr_q + AW'(stride_q);
                        end
                    end else begin
                        x_d = x_adv[LEN_W-1:0];
                    end
                end
            end

            ST_DRAIN: begin
                // Looking at the next count lets done land in the cycle right
                // after the final beat is accepted.
                if (cq_count_d == '0) begin
                    state_d         = ST_IDLE;
                    done_d          = 1'b1;
                    layer_process_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q         <= ST_IDLE;
            layer_process_q <= 1'b0;
            done_q          <= 1'b0;
            stride_q        <= '0;
            width_q         <= '0;
            height_q        <= '0;
            x_q             <= '0;
            y_q             <= '0;
            line_addr_q     <= '0;
            stall_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cq_count_q      <= '0;
            beat_q          <= '0;
            for (int i = 0; i < CQ_DEPTH; i++) begin
                cq_mem_q[i] <= '0;
            end
`ifdef SDP_RDMA_MULTI_SURF_EN
            channel_q       <= '0;
            surf_q          <= '0;
            surf_stride_q   <= '0;
            surf_addr_q     <= '0;
`endif
        end else begin
            state_q         <= state_d;
            layer_process_q <= layer_process_d;
            done_q          <= done_d;
            stride_q        <= stride_d;
            width_q         <= width_d;
            height_q        <= height_d;
            x_q             <= x_d;
            y_q             <= y_d;
            line_addr_q     <= line_addr_d;
            stall_q         <= stall_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            cq_count_q      <= cq_count_d;
            beat_q          <= beat_d;
            cq_mem_q        <= cq_mem_d;
`ifdef SDP_RDMA_MULTI_SURF_EN
            channel_q       <= channel_d;
            surf_q          <= surf_d;
            surf_stride_q   <= surf_stride_d;
            surf_addr_q     <= surf_addr_d;
`endif
        end
    end

    assign layer_process = layer_process_q;
    assign dp2reg_done   = done_q;
    assign dp2reg_stall  = stall_q;
    assign cq_count      = cq_count_q;

endmodule

// File: tb/tb_sdp_rdma_layer_seq.sv
// Testbench for sdp_rdma_layer_seq (single-surface build, CQ_DEPTH=2).
// Expected requests are generated per layer from the surface geometry and
// queued; each accepted request is popped and compared. A model of the
// outstanding-request queue tracks the expected cq_count, rsp_ready and the
// cycle in which dp2reg_done must pulse.

module tb_sdp_rdma_layer_seq;

    localparam int AW        = 64;
    localparam int LEN_W     = 13;
    localparam int CQ_DEPTH  = 2;
    localparam int MAX_BURST = 4;
    localparam int ATOM      = 32;
    localparam int STALL_W   = 32;
    localparam int SZ_W      = 2;
    localparam int CNT_W     = 2;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               op_en = 1'b0;
    logic [AW-1:0]      base = '0;
    logic [31:0]        stride = '0;
    logic [LEN_W-1:0]   width = '0;
    logic [LEN_W-1:0]   height = '0;
    logic               perf_en = 1'b0;
    logic               req_valid;
    logic               req_ready = 1'b0;
    logic [AW-1:0]      req_addr;
    logic [SZ_W-1:0]    req_size;
    logic               rsp_valid = 1'b0;
    logic               rsp_ready;
    logic               op_load;
    logic               layer_process;
    logic               dp2reg_done;
    logic [STALL_W-1:0] dp2reg_stall;
    logic [CNT_W-1:0]   cq_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [SZ_W-1:0] size;
    } req_t;

    req_t exp_q[$];

    sdp_rdma_layer_seq #(
        .AW(AW), .LEN_W(LEN_W), .CQ_DEPTH(CQ_DEPTH), .MAX_BURST(MAX_BURST),
        .ATOM_BYTES(ATOM), .STALL_W(STALL_W)
    ) dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rstn    (rstn),
        .reg2dp_op_en       (op_en),
        .reg2dp_base_addr   (base),
        .reg2dp_line_stride (stride),
        .reg2dp_width       (width),
        .reg2dp_height      (height),
        .reg2dp_perf_dma_en (perf_en),
        .dma_rd_req_valid   (req_valid),
        .dma_rd_req_ready   (req_ready),
        .dma_rd_req_addr    (req_addr),
        .dma_rd_req_size    (req_size),
        .dma_rd_rsp_valid   (rsp_valid),
        .dma_rd_rsp_ready   (rsp_ready),
        .op_load            (op_load),
        .layer_process      (layer_process),
        .dp2reg_done        (dp2reg_done),
        .dp2reg_stall       (dp2reg_stall),
        .cq_count           (cq_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [8:0] outs;
        rstn = 1'b0; op_en = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; perf_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        outs = {req_valid, rsp_ready, op_load, layer_process, dp2reg_done,
                |req_addr, |req_size, |dp2reg_stall, |cq_count};
        checks++;
        if (outs !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 000000000", outs);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one layer. mode: 0 ready/valid always high, 1 random,
    // 2 responses withheld for 8 cycles, 3 request ready withheld for 7 cycles.
    task automatic test_layer(input string name, input logic [AW-1:0] b, input int w, input int h,
                              input logic [31:0] s, input int mode, input int exp_stall);
        req_t e;
        int   x, n, beats, exp_beats, pushes, bm, cnt_before;
        bit   fin, done_due, simul_due, push_c, pop_c;
        int   sz_q[$];

        exp_q.delete();
        sz_q.delete();
        for (int y = 0; y <= h; y++) begin
            x = 0;
            while (x <= w) begin
                n = ((w + 1 - x) < MAX_BURST) ? (w + 1 - x) : MAX_BURST;
                e.addr = b + AW'(y) * AW'(s) + AW'(x) * AW'(ATOM);
                e.size = SZ_W'(n - 1);
                exp_q.push_back(e);
                x += n;
            end
        end
        exp_beats = (w + 1) * (h + 1);
        beats = 0; pushes = 0; bm = 0; cnt_before = 0;
        fin = 1'b0; done_due = 1'b0; simul_due = 1'b0;

        base = b; stride = s; width = LEN_W'(w); height = LEN_W'(h);
        req_ready = 1'b0; rsp_valid = 1'b0; op_en = 1'b1;
        #1;
        checks++;
        if (op_load !== 1'b1) begin
            failures++;
            $display("FAIL %s op_load: got %b want 1", name, op_load);
        end
        @(posedge clk);
        #1;
        op_en = 1'b0;
        checks++;
        if (layer_process !== 1'b1) begin
            failures++;
            $display("FAIL %s layer_start: layer_process got %b want 1", name, layer_process);
        end
        checks++;
        if (dp2reg_stall !== '0) begin
            failures++;
            $display("FAIL %s stall_clear: got %0d want 0", name, dp2reg_stall);
        end

        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            checks++;
            if (int'(cq_count) != sz_q.size()) begin
                failures++;
                $display("FAIL %s cq_count: cycle %0d got %0d want %0d", name, cyc, cq_count, sz_q.size());
            end
            if (simul_due) begin
                checks++;
                if (int'(cq_count) != cnt_before) begin
                    failures++;
                    $display("FAIL %s cq_simul: got %0d want %0d", name, cq_count, cnt_before);
                end
                simul_due = 1'b0;
            end
            if (done_due) begin
                checks++;
                if (dp2reg_done !== 1'b1) begin
                    failures++;
                    $display("FAIL %s done: got %b want 1 after final beat", name, dp2reg_done);
                end
                checks++;
                if (layer_process !== 1'b0) begin
                    failures++;
                    $display("FAIL %s layer_end: layer_process got %b want 0", name, layer_process);
                end
                checks++;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL %s requests: %0d expected requests never issued, want 0", name, exp_q.size());
                end
                fin = 1'b1;
            end else begin
                checks++;
                if (dp2reg_done !== 1'b0) begin
                    failures++;
                    $display("FAIL %s early_done: got %b want 0 at beat %0d of %0d", name, dp2reg_done, beats, exp_beats);
                end
                if (mode == 2 && cyc == 8) begin
                    checks++;
                    if (pushes != CQ_DEPTH || req_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL %s cq_block: accepted %0d valid %b want %0d valid 0", name, pushes, req_valid, CQ_DEPTH);
                    end
                end
                case (mode)
                    1: begin
                        req_ready = 1'($urandom_range(0, 1));
                        rsp_valid = 1'($urandom_range(0, 1));
                    end
                    2: begin
                        req_ready = 1'b1;
                        rsp_valid = (cyc >= 8);
                    end
                    3: begin
                        req_ready = (cyc >= 7);
                        rsp_valid = 1'b1;
                    end
                    default: begin
                        req_ready = 1'b1;
                        rsp_valid = 1'b1;
                    end
                endcase
                #1;
                checks++;
                if (rsp_ready !== (sz_q.size() != 0)) begin
                    failures++;
                    $display("FAIL %s rsp_ready: got %b want %b", name, rsp_ready, (sz_q.size() != 0));
                end
                cnt_before = sz_q.size();
                pop_c = 1'b0;
                if (rsp_valid && rsp_ready && sz_q.size() != 0) begin
                    beats++;
                    bm++;
                    if (bm == sz_q[0] + 1) begin
                        void'(sz_q.pop_front());
                        bm = 0;
                        pop_c = 1'b1;
                    end
                    if (beats == exp_beats) done_due = 1'b1;
                end
                push_c = req_valid && req_ready;
                if (push_c) begin
                    pushes++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL %s extra_req: got addr %h size %0d want no request", name, req_addr, req_size);
                    end else begin
                        e = exp_q.pop_front();
                        if (req_addr !== e.addr || req_size !== e.size) begin
                            failures++;
                            $display("FAIL %s req: got (%h,%0d) want (%h,%0d)", name, req_addr, req_size, e.addr, e.size);
                        end
                        sz_q.push_back(int'(e.size));
                    end
                end
                if (push_c && pop_c) simul_due = 1'b1;
                @(posedge clk);
                #1;
            end
        end

        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: beats %0d of %0d, done never seen", name, beats, exp_beats);
        end
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        checks++;
        if (dp2reg_stall !== STALL_W'(exp_stall)) begin
            failures++;
            $display("FAIL %s stall: got %0d want %0d", name, dp2reg_stall, exp_stall);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dp2reg_done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse: got %b want 0 one cycle after done", name, dp2reg_done);
        end
        checks++;
        if (dp2reg_stall !== STALL_W'(exp_stall)) begin
            failures++;
            $display("FAIL %s stall_hold: got %0d want %0d", name, dp2reg_stall, exp_stall);
        end
    endtask

    task automatic test_rsp_empty();
        rsp_valid = 1'b1;
        #1;
        checks++;
        if (rsp_ready !== 1'b0) begin
            failures++;
            $display("FAIL rsp_empty_ready: got %b want 0", rsp_ready);
        end
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        checks++;
        if (cq_count !== '0) begin
            failures++;
            $display("FAIL rsp_empty_count: got %0d want 0", cq_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [8:0] outs;
        base = 64'h4000; stride = '0; width = LEN_W'(3); height = '0;
        req_ready = 1'b1; rsp_valid = 1'b0; op_en = 1'b1;
        @(posedge clk);
        #1;
        op_en = 1'b0;
        @(posedge clk);
        #1;
        rsp_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        req_ready = 1'b0;
        checks++;
        if (cq_count !== CNT_W'(1) || layer_process !== 1'b1) begin
            failures++;
            $display("FAIL drain_setup: cq_count %0d layer_process %b want 1 1", cq_count, layer_process);
        end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        outs = {req_valid, rsp_ready, op_load, layer_process, dp2reg_done,
                |req_addr, |req_size, |dp2reg_stall, |cq_count};
        checks++;
        if (outs !== 9'b0) begin
            failures++;
            $display("FAIL reset_mid_drain: got %b want 000000000", outs);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_layer("single", 64'h1000, 0, 0, 32'h0, 0, 0);
        test_layer("two_lines", 64'h0, 9, 1, 32'h400, 0, 0);
        test_layer("random", 64'h10000, 6, 2, 32'h200, 1, 0);
        test_layer("cq_backpressure", 64'h2000, 15, 0, 32'h0, 2, 0);
        perf_en = 1'b1;
        test_layer("stall", 64'h0, 0, 0, 32'h0, 3, 7);
        perf_en = 1'b0;
        test_layer("back_to_back", 64'h8000, 4, 1, 32'h100, 0, 0);
        test_rsp_empty();
        test_reset_mid_drain();
        test_layer("after_reset", 64'h3000, 0, 0, 32'h0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
